// File: rtl/acoustic_pkg.sv
// Shared types and default sizing for the microphone-array frame store.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the default sample width, the default channel/frame geometry with
// their derived counter widths, and the write-side state encoding.
package acoustic_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_CH_NUM    = 8;
    localparam int DEF_FRAME_LEN = 512;

    localparam int CH_W  = $clog2(DEF_CH_NUM);
    localparam int IDX_W = $clog2(DEF_FRAME_LEN);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        FILL     = 2'd1,
        DROP     = 2'd2
    } wr_state_t;

    // Word address width of a two-bank store: {bank, idx, ch}.
    function automatic int store_addr_w(input int ch_num, input int frame_len);
        return 1 + $clog2(frame_len) + $clog2(ch_num);
    endfunction

endpackage

// File: rtl/pingpong_frame_buffer_if.sv
// Bundle of the sample-write stream and the random-access read port.
// Latency: n/a (wiring only).
// Backpressure: none; the writer is never stalled, overrun is flagged instead.
//
// slave  : the frame store (consumes writes/reads, drives status and read data)
// master : the surrounding logic (front end, beamformer)
interface pingpong_frame_buffer_if
    import acoustic_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RD_CH_W  = CH_W,
    parameter int RD_IDX_W = IDX_W
);

    // write stream
    logic                wr_valid;
    logic                wr_sof;
    logic [DATA_W-1:0]   wr_data;

    // read request
    logic                rd_en;
    logic [RD_CH_W-1:0]  rd_ch;
    logic [RD_IDX_W-1:0] rd_idx;
    logic                rd_release;

    // status and read response
    logic                frame_ready;
    logic                rd_valid;
    logic [DATA_W-1:0]   rd_data;
    logic                overrun;
    logic [15:0]         frame_cnt;

    modport slave (
        input  wr_valid, wr_sof, wr_data,
        input  rd_en, rd_ch, rd_idx, rd_release,
        output frame_ready, rd_valid, rd_data, overrun, frame_cnt
    );

    modport master (
        output wr_valid, wr_sof, wr_data,
        output rd_en, rd_ch, rd_idx, rd_release,
        input  frame_ready, rd_valid, rd_data, overrun, frame_cnt
    );

endinterface

// File: rtl/sdp_ram_param.sv
// Generic single-clock simple-dual-port RAM: one write port, one read port.
// Latency: read data 1 cycle after i_re, or 2 cycles with OUT_REG=1.
// Backpressure: none; accepts one write and one read every cycle.
//
// Ports:
//   i_clk                    clock for both ports
//   i_we / i_waddr / i_wdata write port
//   i_re / i_raddr           read request
//   o_rdata                  read data (contents undefined until written)
module sdp_ram_param #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 13,
    parameter int OUT_REG = 1
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_q;

    // No reset on storage or data registers so the array maps to block RAM.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_q <= r_mem[i_raddr];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] r_q_out;
            always_ff @(posedge i_clk) begin
                r_q_out <= r_q;
            end
            assign o_rdata = r_q_out;
        end else begin : g_noreg
            assign o_rdata = r_q;
        end
    endgenerate

endmodule

// File: rtl/pingpong_frame_buffer.sv
// Double-banked PCM frame store: writer fills one bank while reader randomly reads the other.
// Latency: read data 1+OUT_REG cycles after an accepted rd_en; frame_ready the cycle after the last word.
// Backpressure: none on writes (full banks cause a whole frame drop + sticky overrun); reads ignored unless frame_ready.
//
// Ports:
//   i_clk, i_reset  clock and synchronous active-high reset
//   bus (slave)     wr_valid/wr_sof/wr_data sample stream in channel-interleaved order,
//                   rd_en/rd_ch/rd_idx/rd_release read side,
//                   frame_ready/rd_valid/rd_data/overrun/frame_cnt status and read data
module pingpong_frame_buffer
    import acoustic_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CH_NUM    = DEF_CH_NUM,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int OUT_REG   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    pingpong_frame_buffer_if.slave bus
);

    localparam int C_CH_W   = $clog2(CH_NUM);
    localparam int C_IDX_W  = $clog2(FRAME_LEN);
    localparam int C_ADDR_W = store_addr_w(CH_NUM, FRAME_LEN);

    localparam logic [C_CH_W-1:0]  LAST_CH  = C_CH_W'(CH_NUM - 1);
    localparam logic [C_IDX_W-1:0] LAST_IDX = C_IDX_W'(FRAME_LEN - 1);

    // ---------------------------------------------------------------- state
    wr_state_t            r_state;
    logic                 r_check;      // next sample opens a new frame; bank decision pending
    logic                 r_wr_bank;
    logic                 r_rd_bank;
    logic [1:0]           r_full;
    logic [C_CH_W-1:0]    r_ch;
    logic [C_IDX_W-1:0]   r_idx;
    logic                 r_overrun;
    logic [15:0]          r_frame_cnt;
    logic                 r_vld_s1;
    logic                 r_vld_s2;

    // ---------------------------------------------------------------- decode
    logic                 w_sof;
    logic                 w_resync;
    logic                 w_start;
    logic                 w_start_drop;
    logic                 w_step;
    logic                 w_end;
    logic                 w_frame_done;
    logic                 w_wr_en;
    logic [C_CH_W-1:0]    w_wr_ch;
    logic [C_IDX_W-1:0]   w_wr_idx;
    logic [C_ADDR_W-1:0]  w_wr_addr;
    logic [C_ADDR_W-1:0]  w_rd_addr;
    logic                 w_rd_acc;
    logic                 w_release;
    logic [1:0]           w_full_nxt;
    logic                 w_rd_valid;
    logic [DATA_W-1:0]    w_ram_q;

    always_comb begin
        w_sof        = bus.wr_valid & bus.wr_sof;

        // A stray SOF inside a frame restarts it in place; the partial frame is simply overwritten.
        w_resync     = ~r_check & (r_state == FILL) & w_sof & ((r_ch != '0) | (r_idx != '0));

        // w_start: this sample is position 0 of a frame (fresh SOF, post-frame check, or resync).
        // The post-frame check is taken on any valid sample so the bank swap costs no bubble.
        w_start      = r_check ? bus.wr_valid
                               : (((r_state == WAIT_SOF) & w_sof) | w_resync);
        w_start_drop = r_check & bus.wr_valid & r_full[r_wr_bank];

        // w_step: this sample sits at the current (ch, idx) of a frame being filled or dropped.
        w_step       = bus.wr_valid & ~r_check & ~w_resync
                     & ((r_state == FILL) | (r_state == DROP));
        w_end        = w_step & (r_ch == LAST_CH) & (r_idx == LAST_IDX);
        w_frame_done = w_end & (r_state == FILL);

        w_wr_en      = (w_start & ~w_start_drop) | (w_step & (r_state == FILL));
        w_wr_ch      = w_start ? '0 : r_ch;
        w_wr_idx     = w_start ? '0 : r_idx;
        w_wr_addr    = {r_wr_bank, w_wr_idx, w_wr_ch};

        w_rd_acc     = bus.rd_en & r_full[r_rd_bank];
        w_release    = bus.rd_release & r_full[r_rd_bank];
        w_rd_addr    = {r_rd_bank, C_IDX_W'(bus.rd_idx), C_CH_W'(bus.rd_ch)};

        // Release and completion always target different banks (writer only fills an empty bank),
        // so both may land in the same cycle.
        w_full_nxt   = r_full;
        if (w_release) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
        if (w_frame_done) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
    end

    // ---------------------------------------------------------------- write FSM + bank control
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= WAIT_SOF;
            r_check     <= 1'b0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_full      <= 2'b00;
            r_ch        <= '0;
            r_idx       <= '0;
            r_overrun   <= 1'b0;
            r_frame_cnt <= 16'd0;
            r_vld_s1    <= 1'b0;
            r_vld_s2    <= 1'b0;
        end else begin
            if (w_start) begin
                r_check <= 1'b0;
                r_state <= w_start_drop ? DROP : FILL;
                r_ch    <= C_CH_W'(1);
                r_idx   <= '0;
                if (w_start_drop) begin
                    r_overrun <= 1'b1;
                end
            end else if (w_step) begin
                if (r_ch == LAST_CH) begin
                    r_ch  <= '0;
                    r_idx <= r_idx + C_IDX_W'(1);
                end else begin
                    r_ch  <= r_ch + C_CH_W'(1);
                end
                // Counters wrap to 0 on their own; the check flag arms the next-frame decision.
                if (w_end) begin
                    r_check <= 1'b1;
                end
                if (w_frame_done) begin
                    r_wr_bank   <= ~r_wr_bank;
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end
            end

            r_full <= w_full_nxt;
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
            end

            r_vld_s1 <= w_rd_acc;
            r_vld_s2 <= r_vld_s1;
        end
    end

    // ---------------------------------------------------------------- storage
    sdp_ram_param #(
        .DATA_W  (DATA_W),
        .ADDR_W  (C_ADDR_W),
        .OUT_REG (OUT_REG)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_wr_en),
        .i_waddr (w_wr_addr),
        .i_wdata (bus.wr_data),
        .i_re    (w_rd_acc),
        .i_raddr (w_rd_addr),
        .o_rdata (w_ram_q)
    );

    // ---------------------------------------------------------------- outputs
    assign w_rd_valid      = (OUT_REG != 0) ? r_vld_s2 : r_vld_s1;
    assign bus.rd_valid    = w_rd_valid;
    // Uncleared RAM output is masked so rd_data reads 0 whenever no read is being returned.
    assign bus.rd_data     = w_rd_valid ? w_ram_q : '0;
    assign bus.frame_ready = r_full[r_rd_bank];
    assign bus.overrun     = r_overrun;
    assign bus.frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// Directed bench for the ping-pong frame store with a read-data scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_pingpong_frame_buffer;
    import acoustic_pkg::*;

    localparam int CHN    = 8;
    localparam int FLEN   = 512;
    localparam int FWORDS = CHN * FLEN;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pingpong_frame_buffer_if #(.DATA_W(16), .RD_CH_W(3), .RD_IDX_W(9)) bus ();

    pingpong_frame_buffer #(
        .DATA_W    (16),
        .CH_NUM    (CHN),
        .FRAME_LEN (FLEN),
        .OUT_REG   (1)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    typedef struct {
        logic [15:0] dat;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sample value: frame tag in [15:12], linear position idx*CHN+ch in [11:0].
    function automatic logic [15:0] word_val(input int tag, input int pos);
        return 16'((tag << 12) | pos);
    endfunction

    // Scoreboard: every cycle rd_valid must match whether a read is due now.
    always @(negedge clk) begin
        if (!reset) begin
            logic exp_vld;
            exp_vld = (sb_q.size() > 0) && (sb_q[0].due == cyc);
            chk("rd_valid", 32'(bus.rd_valid), 32'(exp_vld));
            if (exp_vld) begin
                chk("rd_data", 32'(bus.rd_data), 32'(sb_q[0].dat));
                void'(sb_q.pop_front());
            end
        end
    end

    task automatic wr_words(input int tag, input int first, input int n, input bit sof_first);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.wr_valid = 1'b1;
            bus.wr_sof   = sof_first && (i == 0);
            bus.wr_data  = word_val(tag, first + i);
        end
        @(negedge clk);
        bus.wr_valid = 1'b0;
        bus.wr_sof   = 1'b0;
    endtask

    task automatic rd_issue(input int ch, input int idx, input logic [15:0] exp, input bit acc);
        @(negedge clk);
        bus.rd_en  = 1'b1;
        bus.rd_ch  = 3'(ch);
        bus.rd_idx = 9'(idx);
        if (acc) sb_q.push_back('{dat: exp, due: cyc + 2});
    endtask

    task automatic rd_done;
        @(negedge clk);
        bus.rd_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic release_pulse;
        @(negedge clk);
        bus.rd_release = 1'b1;
        @(negedge clk);
        bus.rd_release = 1'b0;
    endtask

    initial begin
        bus.wr_valid   = 1'b0;
        bus.wr_sof     = 1'b0;
        bus.wr_data    = '0;
        bus.rd_en      = 1'b0;
        bus.rd_ch      = '0;
        bus.rd_idx     = '0;
        bus.rd_release = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_rd_valid",    32'(bus.rd_valid),    32'd0);
        chk("rst_frame_ready", 32'(bus.frame_ready), 32'd0);
        chk("rst_overrun",     32'(bus.overrun),     32'd0);
        chk("rst_frame_cnt",   32'(bus.frame_cnt),   32'd0);
        reset = 1'b0;

        // 1: first frame into bank 0
        wr_words(0, 0, FWORDS - 1, 1'b1);
        chk("f1_not_ready", 32'(bus.frame_ready), 32'd0);
        wr_words(0, FWORDS - 1, 1, 1'b0);
        chk("f1_ready", 32'(bus.frame_ready), 32'd1);
        chk("f1_cnt",   32'(bus.frame_cnt),   32'd1);

        // 2: single read then a full sweep, one per cycle
        rd_issue(3, 100, 16'h0323, 1'b1);
        rd_done();
        for (int p = 0; p < FWORDS; p++) rd_issue(p % CHN, p / CHN, word_val(0, p), 1'b1);
        rd_done();

        // 3: frame 2 into bank 1, frame 3 dropped, release, frame 4 into bank 0
        wr_words(2, 0, FWORDS, 1'b1);
        chk("f2_cnt",     32'(bus.frame_cnt), 32'd2);
        chk("f2_overrun", 32'(bus.overrun),   32'd0);
        wr_words(3, 0, FWORDS, 1'b1);
        chk("f3_overrun", 32'(bus.overrun),   32'd1);
        chk("f3_cnt",     32'(bus.frame_cnt), 32'd2);
        rd_issue(5, 200, word_val(0, 200 * CHN + 5), 1'b1);
        rd_done();
        release_pulse();
        chk("rel1_ready", 32'(bus.frame_ready), 32'd1);
        rd_issue(1, 7, word_val(2, 7 * CHN + 1), 1'b1);
        rd_done();
        wr_words(4, 0, FWORDS, 1'b1);
        chk("f4_cnt", 32'(bus.frame_cnt), 32'd3);
        release_pulse();
        chk("rel2_ready", 32'(bus.frame_ready), 32'd1);
        rd_issue(7, 511, word_val(4, FWORDS - 1), 1'b1);
        rd_done();
        release_pulse();
        chk("rel3_empty", 32'(bus.frame_ready), 32'd0);

        // 5: reads and release while nothing is ready are ignored
        rd_issue(2, 2, 16'h0000, 1'b0);
        rd_done();
        release_pulse();
        wr_words(5, 0, FWORDS, 1'b1);
        chk("f5_ready_rdbank_kept", 32'(bus.frame_ready), 32'd1);
        rd_issue(6, 9, word_val(5, 9 * CHN + 6), 1'b1);
        rd_done();

        // 4: resync at ch=5, idx=7 (after a reset to clear sticky overrun)
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst2_cnt",     32'(bus.frame_cnt), 32'd0);
        chk("rst2_overrun", 32'(bus.overrun),   32'd0);
        wr_words(6, 0, 7 * CHN + 5, 1'b1);
        wr_words(7, 0, FWORDS - 1, 1'b1);
        chk("rs_not_ready", 32'(bus.frame_ready), 32'd0);
        chk("rs_cnt0",      32'(bus.frame_cnt),   32'd0);
        wr_words(7, FWORDS - 1, 1, 1'b0);
        chk("rs_ready",   32'(bus.frame_ready), 32'd1);
        chk("rs_cnt1",    32'(bus.frame_cnt),   32'd1);
        chk("rs_overrun", 32'(bus.overrun),     32'd0);
        rd_issue(5, 7, word_val(7, 7 * CHN + 5), 1'b1);
        rd_issue(0, 0, word_val(7, 0), 1'b1);
        rd_done();

        // 6: reset during FILL with a read in flight
        wr_words(8, 0, 100, 1'b1);
        @(negedge clk);
        bus.rd_en    = 1'b1;
        bus.rd_ch    = 3'd2;
        bus.rd_idx   = 9'd3;
        bus.wr_valid = 1'b1;
        bus.wr_data  = word_val(8, 100);
        sb_q.push_back('{dat: word_val(7, 3 * CHN + 2), due: cyc + 2});
        @(negedge clk);
        bus.rd_en = 1'b0;
        reset     = 1'b1;
        sb_q.delete();
        @(negedge clk);
        reset        = 1'b0;
        bus.wr_valid = 1'b0;
        chk("rst3_rd_valid",    32'(bus.rd_valid),    32'd0);
        chk("rst3_frame_ready", 32'(bus.frame_ready), 32'd0);
        chk("rst3_cnt",         32'(bus.frame_cnt),   32'd0);
        wr_words(9, 0, FWORDS, 1'b0);
        chk("nosof_cnt",   32'(bus.frame_cnt),   32'd0);
        chk("nosof_ready", 32'(bus.frame_ready), 32'd0);
        wr_words(10, 0, FWORDS, 1'b1);
        chk("post_cnt",   32'(bus.frame_cnt),   32'd1);
        chk("post_ready", 32'(bus.frame_ready), 32'd1);
        rd_issue(4, 300, word_val(10, 300 * CHN + 4), 1'b1);
        rd_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pingpong_frame_buffer.md
Name: pingpong_frame_buffer

Overview:
- Parametrised, double-banked sample frame store that succeeds the fixed 512x16 simple-dual-port RAM.
- Microphone-array front end writes channel-interleaved PCM samples into one bank while the beamformer reads the other, previously completed bank with random (channel, index) addressing.
- Banks swap automatically on frame completion; overrun is detected and reported. Single clock domain.

Parameters:
- DATA_W, 16, sample width in bits
- CH_NUM, 8, microphone channels; power of 2, minimum 2
- FRAME_LEN, 512, samples per channel per frame; power of 2, minimum 4
- OUT_REG, 1, 1 = registered output stage (read latency 2); 0 = read latency 1

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_valid  in  1  sample present on wr_data
- wr_sof  in  1  qualifies wr_valid; marks channel 0 of sample 0 of a frame
- wr_data  in  DATA_W  sample, channel order 0..CH_NUM-1 repeating
- rd_en  in  1  read request
- rd_ch  in  log2(CH_NUM)  read channel
- rd_idx  in  log2(FRAME_LEN)  read sample index
- rd_release  in  1  one-cycle pulse; reader finished with the current read bank
- frame_ready  out  1  read bank holds a complete frame
- rd_valid  out  1  rd_data valid
- rd_data  out  DATA_W  read sample
- overrun  out  1  sticky; frame dropped because both banks were full
- frame_cnt  out  16  completed frames, wraps at 0xFFFF

Behaviour:
- Storage: 2*CH_NUM*FRAME_LEN words. Address = {bank, idx, ch}. Inferred SDP RAM, one write port and one read port, both on clk.
- Reset: all outputs 0; wr_bank=0, rd_bank=0, full[1:0]=0, ch/idx counters 0, write state WAIT_SOF. RAM contents are not cleared.
- Write FSM states:
  - WAIT_SOF: discard samples until wr_valid & wr_sof.
  - FILL: write at {wr_bank, idx, ch}.
    - Increment ch on each accepted sample; on ch==CH_NUM-1, ch wraps to 0 and idx increments.
    - Last word (ch==CH_NUM-1, idx==FRAME_LEN-1): set full[wr_bank], toggle wr_bank, frame_cnt+1, go to CHECK.
  - CHECK: combinational on the next accepted sample.
    - If full[wr_bank]==0, enter FILL.
    - Otherwise set overrun, move to DROP, and discard the whole frame by counting it without writing.
    - At the end of DROP, recheck.
  - The frame swap does not cost a cycle; back-to-back wr_valid is allowed every cycle.
- Resync: wr_sof seen in FILL when ch!=0 or idx!=0 restarts the frame at ch=0, idx=0 in the same bank. The partial frame is discarded and overrun is not set.
- Read:
  - frame_ready = full[rd_bank].
  - rd_en is accepted only when frame_ready=1; otherwise it is ignored and rd_valid stays 0.
  - rd_data/rd_valid appear 1+OUT_REG cycles after an accepted rd_en. Fully pipelined: one read per cycle.
- Release:
  - rd_release with frame_ready=1 clears full[rd_bank] and toggles rd_bank on the next edge.
  - Reads already in the pipeline complete normally.
  - Ignored when frame_ready=0.
- Simultaneous completion of bank b by the writer and release of the other bank: both updates apply in the same cycle.
- Write and read never target the same bank at the same address. The full flags prevent it, so no read-during-write rule is needed.
- reset mid-frame: everything returns to reset state immediately; in-flight rd_valid is cleared.
- frame_cnt counts written frames only, not dropped ones.

Decomposition:
- Shared package `acoustic_pkg`:
  - DATA_W default
  - clog2-based width constants CH_W and IDX_W
  - write-state enum {WAIT_SOF, FILL, DROP}
- One sub-module: `sdp_ram_param`, a generic single-clock SDP RAM with parameters DATA_W, ADDR_W and OUT_REG. It holds the storage and output register only.
- All control logic lives in pingpong_frame_buffer.

Test Plan:
1. Reset, then CH_NUM=8, FRAME_LEN=512. Write one frame (4096 words, value = {idx[8:0], ch[2:0]} zero-extended). Required: frame_ready=1 on the cycle after the last word; frame_cnt=1.
2. Read ch=3, idx=100 with OUT_REG=1. Required: rd_valid 2 cycles later; rd_data=0x0323. A back-to-back read of 4096 addresses returns every word in order, one per cycle.
3. Write frames 2 and 3 without rd_release. Required: frame 2 lands in bank 1; frame 3 is dropped; overrun=1; frame_cnt=2. After rd_release, frame 4 writes into bank 0.
4. Assert wr_sof at ch=5, idx=7 mid-frame. Required: frame restarts; completion occurs only after 4096 further words; overrun stays 0.
5. rd_en with frame_ready=0 → no rd_valid. rd_release with frame_ready=0 → rd_bank unchanged.
6. Assert reset during FILL and with a read in flight. Required: next cycle rd_valid=0, frame_ready=0, frame_cnt=0; samples are ignored until wr_sof.
